dma_ahb_slave_if: RTL and testbench

AHB-Lite slave port for the DMA controller's configuration space. It accepts AHB-Lite transfers and generates the simple register-bus strobes (address, chip-select, write-enable, write-data, combinational read-data) that the DMA control register block consumes. It sits between the system AHB interconnect and the control register block. It adds an alignment/size/range error check and a registered read-data path with one wait state.

---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_ahb_slave_if.sv | 116 +++++++++++
 tb/tb_dma_ahb_slave_if.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AHB-Lite encodings, slave-port state type and
// the per-channel register map offsets.
package dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Each channel owns a 16-byte window; the global status/IRQ word sits
    // just past the last channel.
    localparam int CH_STRIDE  = 16;
    localparam int CH_WR_ADDR = 0;
    localparam int CH_RD_ADDR = 4;
    localparam int CH_LEN     = 8;
    localparam int CH_CTRL    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD1,
        ST_RD2,
        ST_ERR1,
        ST_ERR2
    } ahb_slave_state_t;

endpackage

// File: rtl/dma_ahb_slave_if.sv
// AHB-Lite slave front end for the DMA configuration space: converts bus
// transfers into register-bus strobes with a registered, one-wait read path.
module dma_ahb_slave_if
    import dma_pkg::*;
#(
    parameter int AHB_ADDR_SIZE = 32,
    parameter int AHB_DATA_SIZE = 32,
    parameter int CHANNEL_NUM   = 8,
    parameter int OFFSET_BITS   = 12
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     hsel_i,
    input  logic [AHB_ADDR_SIZE-1:0] haddr_i,
    input  logic [1:0]               htrans_i,
    input  logic                     hwrite_i,
    input  logic [2:0]               hsize_i,
    input  logic [AHB_DATA_SIZE-1:0] hwdata_i,
    input  logic                     hready_i,
    output logic                     hreadyout_o,
    output logic                     hresp_o,
    output logic [AHB_DATA_SIZE-1:0] hrdata_o,
    output logic [AHB_ADDR_SIZE-1:0] c_ad_o,
    output logic                     c_we_o,
    output logic                     c_cs_o,
    output logic [AHB_DATA_SIZE-1:0] c_wd_o,
    input  logic [AHB_DATA_SIZE-1:0] c_rd_i
);

    localparam logic [OFFSET_BITS-1:0] MAX_OFFSET = OFFSET_BITS'(CH_STRIDE * CHANNEL_NUM);

    ahb_slave_state_t state, state_next;

    logic [AHB_ADDR_SIZE-1:0] addr_q;
    logic                     write_q;
    logic [AHB_DATA_SIZE-1:0] hrdata_q;

    logic                   accept;
    logic                   legal;
    logic [OFFSET_BITS-1:0] offset;
    logic                   unused_inputs;

    // Upper address bits are decoded by the interconnect; htrans[0] only
    // distinguishes SEQ from NONSEQ, which this slave treats alike.
    assign unused_inputs = ^{haddr_i[AHB_ADDR_SIZE-1:OFFSET_BITS], htrans_i[0]};

    assign accept = hsel_i & hready_i & htrans_i[1];
    assign offset = haddr_i[OFFSET_BITS-1:0];
    assign legal  = (hsize_i == HSIZE_WORD) && (haddr_i[1:0] == 2'b00) && (offset <= MAX_OFFSET);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept && state != ST_RD1 && state != ST_ERR1) begin
                addr_q  <= {{(AHB_ADDR_SIZE-OFFSET_BITS){1'b0}}, offset};
                write_q <= hwrite_i;
            end
            if (state == ST_RD1) begin
                hrdata_q <= c_rd_i;
            end
        end
    end

    // The first cycle of a read or error response is a fixed wait; every
    // other state is a data-phase end where a new address phase may start.
    always_comb begin
        state_next  = ST_IDLE;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        c_cs_o      = 1'b0;
        c_we_o      = 1'b0;
        c_ad_o      = '0;
        c_wd_o      = '0;
        case (state)
            ST_RD1: begin
                state_next  = ST_RD2;
                hreadyout_o = 1'b0;
                c_cs_o      = 1'b1;
                c_ad_o      = addr_q;
            end
            ST_ERR1: begin
                state_next  = ST_ERR2;
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
            end
            default: begin
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (hwrite_i) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RD1;
                    end
                end
                if (state == ST_WR) begin
                    c_cs_o = 1'b1;
                    c_we_o = write_q;
                    c_ad_o = addr_q;
                    c_wd_o = hwdata_i;
                end
                if (state == ST_ERR2) begin
                    hresp_o = HRESP_ERROR;
                end
            end
        endcase
    end

    assign hrdata_o = hrdata_q;

endmodule

// File: tb/tb_dma_ahb_slave_if.sv
// Directed self-checking bench for dma_ahb_slave_if with a single-slave
// bus where hready_i follows the slave's own hreadyout_o.
module tb_dma_ahb_slave_if;

    logic        clk;
    logic        areset;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hreadyout_o;
    logic        hresp_o;
    logic [31:0] hrdata_o;
    logic [31:0] c_ad_o;
    logic        c_we_o;
    logic        c_cs_o;
    logic [31:0] c_wd_o;
    logic [31:0] c_rd_i;

    int vec_count;
    int miscompares;

    dma_ahb_slave_if #(
        .AHB_ADDR_SIZE(32),
        .AHB_DATA_SIZE(32),
        .CHANNEL_NUM  (8),
        .OFFSET_BITS  (12)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .hsel_i     (hsel_i),
        .haddr_i    (haddr_i),
        .htrans_i   (htrans_i),
        .hwrite_i   (hwrite_i),
        .hsize_i    (hsize_i),
        .hwdata_i   (hwdata_i),
        .hready_i   (hready_i),
        .hreadyout_o(hreadyout_o),
        .hresp_o    (hresp_o),
        .hrdata_o   (hrdata_o),
        .c_ad_o     (c_ad_o),
        .c_we_o     (c_we_o),
        .c_cs_o     (c_cs_o),
        .c_wd_o     (c_wd_o),
        .c_rd_i     (c_rd_i)
    );

    assign hready_i = hreadyout_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                                 input logic write, input logic [2:0] size, input logic [31:0] wdata);
        @(negedge clk);
        hsel_i   = sel;
        haddr_i  = addr;
        htrans_i = trans;
        hwrite_i = write;
        hsize_i  = size;
        hwdata_i = wdata;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " hreadyout"}, {31'd0, hreadyout_o}, 32'd1);
        checkOutput({tag, " hresp"},     {31'd0, hresp_o},     32'd0);
        checkOutput({tag, " cs"},        {31'd0, c_cs_o},      32'd0);
        checkOutput({tag, " ad"},        c_ad_o,               32'd0);
        checkOutput({tag, " wd"},        c_wd_o,               32'd0);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        areset   = 1'b0;
        hsel_i   = 1'b0;
        haddr_i  = '0;
        htrans_i = 2'b00;
        hwrite_i = 1'b0;
        hsize_i  = 3'b010;
        hwdata_i = '0;
        c_rd_i   = '0;

        // Reset held with random bus activity
        for (int i = 0; i < 5; i++) begin
            c_rd_i = $urandom;
            applyStimulus(1'($urandom), $urandom, 2'($urandom), 1'($urandom), 3'($urandom), $urandom);
            checkOutput("rst hreadyout", {31'd0, hreadyout_o}, 32'd1);
            checkOutput("rst hresp",     {31'd0, hresp_o},     32'd0);
            checkOutput("rst hrdata",    hrdata_o,             32'd0);
            checkOutput("rst cs",        {31'd0, c_cs_o},      32'd0);
        end
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        areset = 1'b1;

        // Single write to 0x04
        applyStimulus(1'b1, 32'h0000_0004, 2'b10, 1'b1, 3'b010, 32'h0);
        checkIdle("wr addr phase");
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'hDEAD_BEEF);
        checkOutput("wr cs",        {31'd0, c_cs_o},      32'd1);
        checkOutput("wr we",        {31'd0, c_we_o},      32'd1);
        checkOutput("wr ad",        c_ad_o,               32'h0000_0004);
        checkOutput("wr wd",        c_wd_o,               32'hDEAD_BEEF);
        checkOutput("wr hreadyout", {31'd0, hreadyout_o}, 32'd1);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h1111_2222);
        checkIdle("wr done");

        // Read from 0x80, the highest legal offset
        c_rd_i = 32'h0000_1234;
        applyStimulus(1'b1, 32'hA000_0080, 2'b10, 1'b0, 3'b010, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("rd1 cs",        {31'd0, c_cs_o},      32'd1);
        checkOutput("rd1 we",        {31'd0, c_we_o},      32'd0);
        checkOutput("rd1 ad",        c_ad_o,               32'h0000_0080);
        checkOutput("rd1 hreadyout", {31'd0, hreadyout_o}, 32'd0);
        checkOutput("rd1 hrdata",    hrdata_o,             32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        c_rd_i = 32'hFFFF_0000;
        #1;
        checkOutput("rd2 hreadyout", {31'd0, hreadyout_o}, 32'd1);
        checkOutput("rd2 hresp",     {31'd0, hresp_o},     32'd0);
        checkOutput("rd2 hrdata",    hrdata_o,             32'h0000_1234);
        checkOutput("rd2 cs",        {31'd0, c_cs_o},      32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("rd hold hrdata", hrdata_o, 32'h0000_1234);

        // Back-to-back write 0x0C then read 0x0C
        applyStimulus(1'b1, 32'h0000_000C, 2'b10, 1'b1, 3'b010, 32'h0);
        applyStimulus(1'b1, 32'h0000_000C, 2'b10, 1'b0, 3'b010, 32'h0000_0005);
        checkOutput("b2b wr cs", {31'd0, c_cs_o}, 32'd1);
        checkOutput("b2b wr we", {31'd0, c_we_o}, 32'd1);
        checkOutput("b2b wr ad", c_ad_o,          32'h0000_000C);
        checkOutput("b2b wr wd", c_wd_o,          32'h0000_0005);
        c_rd_i = 32'h0000_0005;
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("b2b rd cs",        {31'd0, c_cs_o},      32'd1);
        checkOutput("b2b rd we",        {31'd0, c_we_o},      32'd0);
        checkOutput("b2b rd ad",        c_ad_o,               32'h0000_000C);
        checkOutput("b2b rd wd",        c_wd_o,               32'h0);
        checkOutput("b2b rd hreadyout", {31'd0, hreadyout_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("b2b rd2 hrdata",    hrdata_o,             32'h0000_0005);
        checkOutput("b2b rd2 hreadyout", {31'd0, hreadyout_o}, 32'd1);

        // Halfword write to 0x08, then out-of-range word write to 0x84
        applyStimulus(1'b1, 32'h0000_0008, 2'b10, 1'b1, 3'b001, 32'h0);
        applyStimulus(1'b1, 32'h0000_0084, 2'b10, 1'b1, 3'b010, 32'h0);
        checkOutput("hw err1 hreadyout", {31'd0, hreadyout_o}, 32'd0);
        checkOutput("hw err1 hresp",     {31'd0, hresp_o},     32'd1);
        checkOutput("hw err1 cs",        {31'd0, c_cs_o},      32'd0);
        applyStimulus(1'b1, 32'h0000_0084, 2'b10, 1'b1, 3'b010, 32'h0);
        checkOutput("hw err2 hreadyout", {31'd0, hreadyout_o}, 32'd1);
        checkOutput("hw err2 hresp",     {31'd0, hresp_o},     32'd1);
        checkOutput("hw err2 cs",        {31'd0, c_cs_o},      32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'hCAFE_0000);
        checkOutput("range err1 hreadyout", {31'd0, hreadyout_o}, 32'd0);
        checkOutput("range err1 hresp",     {31'd0, hresp_o},     32'd1);
        checkOutput("range err1 cs",        {31'd0, c_cs_o},      32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("range err2 hreadyout", {31'd0, hreadyout_o}, 32'd1);
        checkOutput("range err2 hresp",     {31'd0, hresp_o},     32'd1);
        checkOutput("range err2 cs",        {31'd0, c_cs_o},      32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkIdle("after err");

        // Misaligned word read
        applyStimulus(1'b1, 32'h0000_0012, 2'b10, 1'b0, 3'b010, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("misalign hresp", {31'd0, hresp_o}, 32'd1);
        checkOutput("misalign cs",    {31'd0, c_cs_o},  32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("misalign hrdata", hrdata_o, 32'h0000_0005);

        // Reset pulsed during RD1, then a normal read
        c_rd_i = 32'h7777_7777;
        applyStimulus(1'b1, 32'h0000_0010, 2'b10, 1'b0, 3'b010, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("pre-rst rd1 hreadyout", {31'd0, hreadyout_o}, 32'd0);
        areset = 1'b0;
        #1;
        checkIdle("mid rst");
        checkOutput("mid rst hrdata", hrdata_o, 32'd0);
        @(negedge clk);
        areset = 1'b1;
        c_rd_i = 32'hA5A5_A5A5;
        applyStimulus(1'b1, 32'h0000_0014, 2'b10, 1'b0, 3'b010, 32'h0);
        checkOutput("post rst hrdata", hrdata_o, 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("post rst rd1 cs", {31'd0, c_cs_o}, 32'd1);
        checkOutput("post rst rd1 ad", c_ad_o,          32'h0000_0014);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'b010, 32'h0);
        checkOutput("post rst rd2 hrdata",    hrdata_o,             32'hA5A5_A5A5);
        checkOutput("post rst rd2 hreadyout", {31'd0, hreadyout_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
